udp_rx_demux: RTL and testbench

Multi-channel successor to the single UDP receive port of the Ethernet subsystem. It takes the byte stream and first-beat destination-port sideband from the network layer and steers each datagram to one of CH_NUM user channels by destination port. It packs bytes into OUT_BYTES-wide words with byte-keep, and discards datagrams for unmapped ports while counting them. It sits between the network layer's UDP receive output and user logic, in the logic clock domain.

---
 rtl/udp_demux_pkg.sv | 13 +
 rtl/udp_word_packer.sv | 54 +++++
 rtl/udp_rx_demux.sv | 81 ++++++++
 tb/tb_udp_rx_demux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/udp_demux_pkg.sv
// udp_demux_pkg: shared types and helpers for the UDP receive demultiplexer
package udp_demux_pkg;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    // Returns {hit, idx}; the 16-bit difference wraps below base, so low ports miss
    function automatic logic [16:0] port_to_ch(input logic [15:0] port, input logic [15:0] base, input int n);
        logic [15:0] diff;
        diff = port - base;
        return {diff < 16'(n), diff};
    endfunction
endpackage

// File: rtl/udp_word_packer.sv
// udp_word_packer: packs a byte stream into OUT_BYTES-wide words with keep and last
module udp_word_packer #(
    parameter int OUT_BYTES = 4
) (
    input  logic                   logic_clk,
    input  logic                   logic_rstn,
    input  logic                   wr,
    input  logic [7:0]             wr_data,
    input  logic                   wr_last,
    input  logic                   drain,
    output logic [8*OUT_BYTES-1:0] word,
    output logic [OUT_BYTES-1:0]   keep,
    output logic                   valid,
    output logic                   last
);
    localparam int LW = OUT_BYTES > 1 ? $clog2(OUT_BYTES) : 1;

    logic [LW-1:0]          lane;
    logic [8*OUT_BYTES-1:0] word_n;
    logic [OUT_BYTES-1:0]   keep_n;
    logic                   done;

    assign done = wr && (lane == LW'(OUT_BYTES - 1) || wr_last);

    // A lane-0 write starts a fresh word, so unused lanes of a short word read as zero
    always_comb begin
        word_n = (lane == '0) ? '0 : word;
        keep_n = (lane == '0) ? '0 : keep;
        word_n[8*lane +: 8] = wr_data;
        keep_n[lane] = 1'b1;
    end

    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) begin
            lane  <= '0;
            word  <= '0;
            keep  <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            if (wr) begin
                word <= word_n;
                keep <= keep_n;
                lane <= done ? '0 : lane + 1'b1;
            end
            if (done) begin
                valid <= 1'b1;
                last  <= wr_last;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/udp_rx_demux.sv
// udp_rx_demux: steers UDP datagrams to user channels by destination port,
// packing bytes into words and counting datagrams for unmapped ports.
module udp_rx_demux
    import udp_demux_pkg::*;
#(
    parameter int          CH_NUM    = 4,
    parameter logic [15:0] PORT_BASE = 16'd8080,
    parameter int          OUT_BYTES = 4
) (
    input  logic                          logic_clk,
    input  logic                          logic_rstn,
    input  logic [7:0]                    udp_rdata_in,
    input  logic                          udp_rvalid_in,
    output logic                          udp_rready_out,
    input  logic                          udp_rlast_in,
    input  logic [15:0]                   udp_rport_in,
    output logic [CH_NUM*8*OUT_BYTES-1:0] ch_tdata_out,
    output logic [CH_NUM*OUT_BYTES-1:0]   ch_tkeep_out,
    output logic [CH_NUM-1:0]             ch_tvalid_out,
    input  logic [CH_NUM-1:0]             ch_tready_in,
    output logic [CH_NUM-1:0]             ch_tlast_out,
    output logic [DROP_CNT_W-1:0]         drop_cnt_out
);
    localparam int SW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;

    state_t                 state, state_n;
    logic [SW-1:0]          sel, idx;
    logic [15-SW:0]         port_hi_unused;
    logic                   hit, accept, first, wr, drain, valid, last;
    logic [8*OUT_BYTES-1:0] word;
    logic [OUT_BYTES-1:0]   keep;

    assign {hit, port_hi_unused, idx} = port_to_ch(udp_rport_in, PORT_BASE, CH_NUM);

    // The old word may drain in the same cycle a new first beat is accepted
    assign drain          = valid && ch_tready_in[sel];
    assign udp_rready_out = (state == DROP) || !valid || ch_tready_in[sel];
    assign accept         = udp_rvalid_in && udp_rready_out;
    assign first          = accept && (state == IDLE);
    assign wr             = first ? hit : accept && (state == FWD);

    always_comb begin
        state_n = state;
        if (first)
            state_n = udp_rlast_in ? IDLE : (hit ? FWD : DROP);
        else if (accept && udp_rlast_in)
            state_n = IDLE;
    end

    always_ff @(posedge logic_clk or negedge logic_rstn) begin
        if (!logic_rstn) begin
            state        <= IDLE;
            sel          <= '0;
            drop_cnt_out <= '0;
        end else begin
            state <= state_n;
            if (first && hit)
                sel <= idx;
            if (first && !hit && drop_cnt_out != '1)
                drop_cnt_out <= drop_cnt_out + 1'b1;
        end
    end

    udp_word_packer #(.OUT_BYTES(OUT_BYTES)) u_packer (
        .logic_clk (logic_clk),
        .logic_rstn(logic_rstn),
        .wr        (wr),
        .wr_data   (udp_rdata_in),
        .wr_last   (udp_rlast_in),
        .drain     (drain),
        .word      (word),
        .keep      (keep),
        .valid     (valid),
        .last      (last)
    );

    assign ch_tdata_out  = {CH_NUM{word}};
    assign ch_tkeep_out  = {CH_NUM{keep}};
    assign ch_tvalid_out = valid ? CH_NUM'(1) << sel : '0;
    assign ch_tlast_out  = (valid && last) ? CH_NUM'(1) << sel : '0;
endmodule

// File: tb/tb_udp_rx_demux.sv
// tb_udp_rx_demux: directed vector table plus hand-written corner sequences for udp_rx_demux
module tb_udp_rx_demux;
    logic         logic_clk = 1'b0;
    logic         logic_rstn = 1'b0;
    logic [7:0]   rdata = '0;
    logic         rvalid = 1'b0, rlast = 1'b0, rready;
    logic [15:0]  rport = '0;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic [3:0]   tvalid, tlast;
    logic [3:0]   tready = 4'hF;
    logic [15:0]  drop_cnt;
    int           n_cmp = 0, n_bad = 0;

    always #5 logic_clk = ~logic_clk;

    udp_rx_demux #(.CH_NUM(4), .PORT_BASE(16'd8080), .OUT_BYTES(4)) dut (
        .logic_clk     (logic_clk),
        .logic_rstn    (logic_rstn),
        .udp_rdata_in  (rdata),
        .udp_rvalid_in (rvalid),
        .udp_rready_out(rready),
        .udp_rlast_in  (rlast),
        .udp_rport_in  (rport),
        .ch_tdata_out  (tdata),
        .ch_tkeep_out  (tkeep),
        .ch_tvalid_out (tvalid),
        .ch_tready_in  (tready),
        .ch_tlast_out  (tlast),
        .drop_cnt_out  (drop_cnt)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic [15:0] p;
        logic [3:0]  rdy;
        logic        e_rr;
        logic [3:0]  e_tv;
        logic [3:0]  e_tl;
        logic [3:0]  e_keep;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t       vq[$];
    logic [7:0] got[$];
    int         n_last;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l, input logic [15:0] p,
                                input logic e_rr, input logic [3:0] e_tv, input logic [3:0] e_tl,
                                input logic [3:0] e_keep, input logic [31:0] e_data, input logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.p = p; r.rdy = 4'hF;
        r.e_rr = e_rr; r.e_tv = e_tv; r.e_tl = e_tl; r.e_keep = e_keep; r.e_data = e_data; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [15:0] p, input logic [3:0] rdy);
        @(negedge logic_clk);
        rvalid = v; rdata = d; rlast = l; rport = p; tready = rdy;
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rready", 128'(rready), 128'(1));
        chk("rst_tvalid", 128'(tvalid), 128'(0));
        chk("rst_tlast", 128'(tlast), 128'(0));
        chk("rst_tkeep", 128'(tkeep), 128'(0));
        chk("rst_tdata", tdata, 128'(0));
        chk("rst_drop", 128'(drop_cnt), 128'(0));
        @(negedge logic_clk);
        logic_rstn = 1'b1;

        // 10 bytes to 8082 (ch2); later beats carry a junk port to show it is sampled once
        vq.push_back(mk(1, 8'h10, 0, 16'd8082, 1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h11, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h12, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h13, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h14, 0, 16'd0,    1, 4'h4, 4'h0, 4'hF, 32'h13121110, 16'd0));
        vq.push_back(mk(1, 8'h15, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h16, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h17, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'h18, 0, 16'd0,    1, 4'h4, 4'h0, 4'hF, 32'h17161514, 16'd0));
        vq.push_back(mk(1, 8'h19, 1, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h4, 4'h4, 4'h3, 32'h00001918, 16'd0));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        // 5 bytes to unmapped 9000, then 3 bytes to 8080 (ch0)
        vq.push_back(mk(1, 8'hA0, 0, 16'd9000, 1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd0));
        vq.push_back(mk(1, 8'hA1, 0, 16'd8081, 1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hA2, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hA3, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hA4, 1, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hB0, 0, 16'd8080, 1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hB1, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hB2, 1, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h1, 4'h1, 4'h7, 32'h00B2B1B0, 16'd1));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        // Port 8079 wraps below the base and is a miss
        vq.push_back(mk(1, 8'hD0, 0, 16'd8079, 1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd1));
        vq.push_back(mk(1, 8'hD1, 1, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd2));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd2));
        // Back-to-back single-byte datagrams alternating ch3/ch0
        vq.push_back(mk(1, 8'hC0, 1, 16'd8083, 1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd2));
        vq.push_back(mk(1, 8'hC1, 1, 16'd8080, 1, 4'h8, 4'h8, 4'h1, 32'h000000C0, 16'd2));
        vq.push_back(mk(1, 8'hC2, 1, 16'd8083, 1, 4'h1, 4'h1, 4'h1, 32'h000000C1, 16'd2));
        vq.push_back(mk(1, 8'hC3, 1, 16'd8080, 1, 4'h8, 4'h8, 4'h1, 32'h000000C2, 16'd2));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h1, 4'h1, 4'h1, 32'h000000C3, 16'd2));
        vq.push_back(mk(0, 8'h00, 0, 16'd0,    1, 4'h0, 4'h0, 4'h0, 32'h0, 16'd2));

        foreach (vq[i]) begin
            drive(vq[i].v, vq[i].d, vq[i].l, vq[i].p, vq[i].rdy);
            chk($sformatf("v%0d_rready", i), 128'(rready), 128'(vq[i].e_rr));
            chk($sformatf("v%0d_tvalid", i), 128'(tvalid), 128'(vq[i].e_tv));
            chk($sformatf("v%0d_drop", i), 128'(drop_cnt), 128'(vq[i].e_cnt));
            if (vq[i].e_tv != 4'h0) begin
                chk($sformatf("v%0d_tlast", i), 128'(tlast), 128'(vq[i].e_tl));
                chk($sformatf("v%0d_tkeep", i), 128'(tkeep), 128'({4{vq[i].e_keep}}));
                chk($sformatf("v%0d_tdata", i), tdata, {4{vq[i].e_data}});
            end
        end

        // ch1 stalled for 20 cycles mid-datagram; the source honours rready
        begin
            int idx;
            idx = 0;
            n_last = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                drive(idx < 12, 8'h20 + 8'(idx), idx == 11, 16'd8081, (cyc >= 6 && cyc < 26) ? 4'b1101 : 4'hF);
                if (cyc == 8) begin
                    chk("stall_rready", 128'(rready), 128'(0));
                    chk("stall_tvalid", 128'(tvalid), 128'(4'b0010));
                end
                if (tvalid[1] && tready[1]) begin
                    for (int k = 0; k < 4; k++)
                        if (tkeep[4+k]) got.push_back(tdata[32+8*k +: 8]);
                    if (tlast[1]) n_last++;
                end
                if (idx < 12 && rready) idx++;
            end
            chk("stall_nbytes", 128'(got.size()), 128'(12));
            chk("stall_nlast", 128'(n_last), 128'(1));
            foreach (got[i]) chk($sformatf("stall_byte%0d", i), 128'(got[i]), 128'(8'h20 + 8'(i)));
        end

        // Reset pulsed while a word is held on ch3
        for (int i = 0; i < 4; i++) drive(1, 8'hF0 + 8'(i), 0, 16'd8083, 4'b0111);
        drive(0, 8'h00, 0, 16'd0, 4'b0111);
        chk("prerst_tvalid", 128'(tvalid), 128'(4'h8));
        logic_rstn = 1'b0;
        #1;
        chk("arst_tvalid", 128'(tvalid), 128'(0));
        chk("arst_tdata", tdata, 128'(0));
        chk("arst_tkeep", 128'(tkeep), 128'(0));
        chk("arst_tlast", 128'(tlast), 128'(0));
        chk("arst_drop", 128'(drop_cnt), 128'(0));
        chk("arst_rready", 128'(rready), 128'(1));
        @(negedge logic_clk);
        logic_rstn = 1'b1;
        drive(1, 8'hE0, 0, 16'd8081, 4'hF);
        drive(1, 8'hE1, 0, 16'd0, 4'hF);
        drive(1, 8'hE2, 1, 16'd0, 4'hF);
        drive(0, 8'h00, 0, 16'd0, 4'hF);
        chk("postrst_tvalid", 128'(tvalid), 128'(4'h2));
        chk("postrst_tlast", 128'(tlast), 128'(4'h2));
        chk("postrst_tkeep", 128'(tkeep), 128'({4{4'h7}}));
        chk("postrst_tdata", tdata, {4{32'h00E2E1E0}});

        // Drop counter saturation
        for (int i = 0; i < 65535; i++) drive(1, 8'h55, 1, 16'd9000, 4'hF);
        drive(0, 8'h00, 0, 16'd0, 4'hF);
        chk("sat_reach", 128'(drop_cnt), 128'(16'hFFFF));
        drive(1, 8'h55, 1, 16'd9000, 4'hF);
        drive(1, 8'h55, 1, 16'd8079, 4'hF);
        drive(0, 8'h00, 0, 16'd0, 4'hF);
        chk("sat_hold", 128'(drop_cnt), 128'(16'hFFFF));
        chk("sat_tvalid", 128'(tvalid), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
